// File: rtl/dm_arbiter_if.sv
// Requester-side word-access handshake for the data memory arbiter.
// master = requester (CPU MEM stage or loader), slave = arbiter.
interface dm_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              gnt;
  logic              done;
  logic              err;
  logic [31:0]       rdata;

  modport master (output req, we, addr, wdata, input gnt, done, err, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, done, err, rdata);
endinterface

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter and sequencer for the 128-byte big-endian DM.
// One word access per grant; illegal addresses are reported, never issued to DM.
module dm_arbiter #(
  parameter int MEM_SIZE = 128,
  parameter int ADDR_W   = 32
) (
  input  logic         clk,
  input  logic         rst,
  dm_arbiter_if.slave  m0,
  dm_arbiter_if.slave  m1,
  output logic [31:0]  dm_MemAddr,
  output logic [31:0]  dm_MemWriteData,
  output logic         dm_MemWrite,
  output logic         dm_MemRead,
  input  logic [31:0]  dm_MemReadData
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_q, state_d;
  logic              last_q;
  logic              win_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        gnt_q, done_q, err_q;
  logic [31:0]       rdata0_q, rdata1_q;

  logic el0, el1, grant, winner, illegal;

  // A requester still holding req during its done cycle is not re-eligible yet.
  assign el0 = m0.req & ~done_q[0];
  assign el1 = m1.req & ~done_q[1];

  assign illegal = (addr_q[1:0] != 2'b00) || (addr_q > ADDR_W'(MEM_SIZE - 4));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    winner  = 1'b0;
    case (state_q)
      IDLE: begin
        if (el0 | el1) begin
          grant   = 1'b1;
          // Port 1 wins when alone, or on a tie when port 1 was not last served.
          winner  = el1 & (~el0 | ~last_q);
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = IDLE;
    endcase
  end

  always_comb begin
    dm_MemAddr      = '0;
    dm_MemWriteData = '0;
    dm_MemWrite     = 1'b0;
    dm_MemRead      = 1'b0;
    if (state_q == ACCESS) begin
      dm_MemAddr      = 32'(addr_q);
      dm_MemWriteData = wdata_q;
      dm_MemWrite     = ~illegal & we_q;
      dm_MemRead      = ~illegal & ~we_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      err_q  <= '0;
      if (grant) begin
        last_q  <= winner;
        win_q   <= winner;
        we_q    <= winner ? m1.we    : m0.we;
        addr_q  <= winner ? m1.addr  : m0.addr;
        wdata_q <= winner ? m1.wdata : m0.wdata;
        gnt_q   <= winner ? 2'b10 : 2'b01;
      end
      if (state_q == ACCESS) begin
        done_q <= win_q ? 2'b10 : 2'b01;
        err_q  <= win_q ? {illegal, 1'b0} : {1'b0, illegal};
        if (!illegal && !we_q) begin
          if (win_q) rdata1_q <= dm_MemReadData;
          else       rdata0_q <= dm_MemReadData;
        end
      end
    end
  end

  assign m0.gnt   = gnt_q[0];
  assign m1.gnt   = gnt_q[1];
  assign m0.done  = done_q[0];
  assign m1.done  = done_q[1];
  assign m0.err   = err_q[0];
  assign m1.err   = err_q[1];
  assign m0.rdata = rdata0_q;
  assign m1.rdata = rdata1_q;

endmodule
